traffic_ctl: RTL and testbench



---
 rtl/traffic_pkg.sv | 29 ++
 rtl/traffic_ctl.sv | 144 ++++++++++++++
 tb/tb_traffic_ctl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the two-road traffic-light sequencer: lamp codes,
// the controller state encoding and a small helper for sizing the tick counter.
package traffic_pkg;

  localparam logic [1:0] LAMP_RED = 2'b00;
  localparam logic [1:0] LAMP_YEL = 2'b01;
  localparam logic [1:0] LAMP_GRN = 2'b10;

  typedef enum logic [2:0] {
    INIT,
    MAIN_G,
    MAIN_Y,
    RED_MS,
    SIDE_G,
    SIDE_Y,
    RED_SM
  } tl_state_t;

  // Largest of the four phase lengths; sets the tick counter width.
  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/traffic_ctl.sv
// Two-road traffic-light sequencer. Restarts the paired countdown timer on
// each of its expirations and holds every lamp phase for a parameterized
// number of timer periods. Main road rests on green until a side car or a
// pedestrian request asks for the side road.
module traffic_ctl
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS  = 3,
  parameter int YELLOW_TICKS = 2,
  parameter int CLEAR_TICKS  = 1,
  parameter int SIDE_TICKS   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tmr_done,
  input  logic       side_car,
  input  logic       ped_btn,
  output logic       tmr_start,
  output logic [1:0] main_light,
  output logic [1:0] side_light,
  output logic       walk
);

  localparam int MAX_TICKS = max_of4(GREEN_TICKS, YELLOW_TICKS, CLEAR_TICKS, SIDE_TICKS);
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  tl_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ped_req_q, ped_req_d;
  logic             walk_q, walk_d;
  logic             tmr_start_q, tmr_start_d;
  logic             expiry;
  logic             enter_side_g;

  // Counter value loaded on phase entry: a phase of N ticks counts N-1 .. 0.
  function automatic logic [CNT_W-1:0] reload(input int ticks);
    return CNT_W'(ticks - 1);
  endfunction

  // The timer still shows the previous done in the cycle start is issued,
  // so an expiry only counts when start is not being driven.
  assign expiry = tmr_done & ~tmr_start_q;

  // Next-state, phase counter, timer restart and pedestrian bookkeeping.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    enter_side_g = 1'b0;

    if (expiry) begin
      if (state_q != INIT && cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        case (state_q)
          INIT: begin
            state_d = MAIN_G;
            cnt_d   = reload(GREEN_TICKS);
          end
          MAIN_G: begin
            // Rest on green (counter stays 0) until someone wants the side road.
            if (side_car | ped_req_q | ped_btn) begin
              state_d = MAIN_Y;
              cnt_d   = reload(YELLOW_TICKS);
            end
          end
          MAIN_Y: begin
            state_d = RED_MS;
            cnt_d   = reload(CLEAR_TICKS);
          end
          RED_MS: begin
            state_d      = SIDE_G;
            cnt_d        = reload(SIDE_TICKS);
            enter_side_g = 1'b1;
          end
          SIDE_G: begin
            state_d = SIDE_Y;
            cnt_d   = reload(YELLOW_TICKS);
          end
          SIDE_Y: begin
            state_d = RED_SM;
            cnt_d   = reload(CLEAR_TICKS);
          end
          RED_SM: begin
            state_d = MAIN_G;
            cnt_d   = reload(GREEN_TICKS);
          end
          default: begin
            state_d = INIT;
            cnt_d   = '0;
          end
        endcase
      end
    end

    tmr_start_d = expiry;
    // A press landing in the SIDE_G entry cycle is served by this visit.
    ped_req_d   = enter_side_g ? 1'b0 : (ped_req_q | ped_btn);
    walk_d      = enter_side_g ? (ped_req_q | ped_btn) : walk_q;
  end

  // State register with synchronous reset; a reset abandons any phase.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      ped_req_q   <= 1'b0;
      walk_q      <= 1'b0;
      tmr_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ped_req_q   <= ped_req_d;
      walk_q      <= walk_d;
      tmr_start_q <= tmr_start_d;
    end
  end

  assign tmr_start = tmr_start_q;

  // Lamp and walk decode from the registered state only.
  always_comb begin
    main_light = LAMP_RED;
    side_light = LAMP_RED;
    walk       = 1'b0;
    case (state_q)
      MAIN_G: main_light = LAMP_GRN;
      MAIN_Y: main_light = LAMP_YEL;
      SIDE_G: begin
        side_light = LAMP_GRN;
        walk       = walk_q;
      end
      SIDE_Y: side_light = LAMP_YEL;
      default: begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_ctl.sv
// Scoreboard bench for traffic_ctl with a behavioural countdown timer (D=4,
// five cycles per tick). Stimulus queues the expected lamp segments (lamp
// pair, walk, duration); a monitor closes a segment whenever the lamps change
// and compares it against the head of the queue.
module tb_traffic_ctl;

  localparam int         D = 4;
  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;

  typedef struct {
    logic [1:0] m;
    logic [1:0] s;
    logic       w;
    int         len;   // exact length, or minimum when closed by a flush
  } seg_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tmr_done;
  logic       side_car = 1'b0;
  logic       ped_btn = 1'b0;
  logic       tmr_start;
  logic [1:0] main_light;
  logic [1:0] side_light;
  logic       walk;

  bit   quick_clear = 1'b0;  // timer drops done during the start cycle
  bit   mon_en = 1'b0;
  int   flush_cnt = 0;
  int   tcnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  seg_t exp_q[$];

  always #5 clk = ~clk;

  traffic_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .tmr_done   (tmr_done),
    .side_car   (side_car),
    .ped_btn    (ped_btn),
    .tmr_start  (tmr_start),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk)
  );

  // Behavioural paired timer: done is high out of reset and D cycles after start.
  always @(posedge clk) begin
    if (rst)            tcnt <= 0;
    else if (tmr_start) tcnt <= D - 1;
    else if (tcnt != 0) tcnt <= tcnt - 1;
  end
  assign tmr_done = (tcnt == 0) && !(quick_clear && tmr_start);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_min(input string name, input int act, input int min_v);
    n_checks++;
    if (act < min_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected at least %0d (t=%0t)", name, act, min_v, $time);
    end
  endtask

  task automatic push(input logic [1:0] m, input logic [1:0] s, input logic w, input int len);
    seg_t e;
    e.m = m; e.s = s; e.w = w; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic close_seg(input logic [4:0] lamps, input int run, input bit open);
    seg_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL seg_unexpected: got lamps %b for %0d cycles, none expected", lamps, run);
      return;
    end
    e = exp_q.pop_front();
    check("seg_lamps", 32'(lamps), 32'({e.m, e.s, e.w}));
    if (open) check_min("seg_min_len", run, e.len);
    else      check("seg_len", 32'(run), 32'(e.len));
  endtask

  // Monitor: segment tracking plus per-cycle invariants.
  initial begin : monitor
    logic [4:0] cur;
    logic [4:0] now;
    logic       prev_start;
    bit         have_cur;
    int         run;
    int         seen_flush;
    int         cyc;
    int         last_start;
    cur = '0; have_cur = 0; run = 0; seen_flush = 0; cyc = 0;
    last_start = -1; prev_start = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (flush_cnt != seen_flush) begin
        if (have_cur) close_seg(cur, run, 1'b1);
        have_cur   = 0;
        seen_flush = flush_cnt;
        last_start = -1;
        prev_start = 1'b0;
      end
      if (mon_en) begin
        cyc++;
        now = {main_light, side_light, walk};
        if (!have_cur) begin
          cur = now; run = 1; have_cur = 1;
        end else if (now === cur) begin
          run++;
        end else begin
          close_seg(cur, run, 1'b0);
          cur = now; run = 1;
        end
        check("one_road_non_red", 32'(main_light != R && side_light != R), 32'(0));
        check("no_code_11", 32'(main_light == 2'b11 || side_light == 2'b11), 32'(0));
        check("start_not_double", 32'(tmr_start & prev_start), 32'(0));
        if (tmr_start === 1'b1) begin
          if (last_start >= 0) check("start_period", 32'(cyc - last_start), 32'(D + 1));
          last_start = cyc;
        end
        prev_start = tmr_start;
      end
    end
  end

  // Called at a negedge; returns at the negedge of the first post-reset cycle.
  task automatic do_reset();
    flush_cnt++;
    rst    = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_main_red", 32'(main_light), 32'(R));
    check("rst_side_red", 32'(side_light), 32'(R));
    check("rst_tmr_start", 32'(tmr_start), 32'(0));
    check("rst_walk", 32'(walk), 32'(0));
    rst = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Side car present from reset: one full side service, then green again.
  task automatic run_side_loop();
    do_reset();
    side_car = 1'b1;
    push(R, R, 1'b0, 1);
    push(G, R, 1'b0, 15);
    push(Y, R, 1'b0, 10);
    push(R, R, 1'b0, 5);
    push(R, G, 1'b0, 10);
    push(R, Y, 1'b0, 10);
    push(R, R, 1'b0, 5);
    push(G, R, 1'b0, 15);
    push(Y, R, 1'b0, 2);
    wait_cycles(74);
  endtask

  initial begin
    @(negedge clk);

    // Idle: main green forever.
    do_reset();
    side_car = 1'b0;
    push(R, R, 1'b0, 1);
    push(G, R, 1'b0, 55);
    wait_cycles(60);

    // Side car, timer drops done during start.
    quick_clear = 1'b1;
    run_side_loop();

    // Pedestrian pulse while resting on main green.
    quick_clear = 1'b0;
    do_reset();
    side_car = 1'b0;
    push(R, R, 1'b0, 1);
    push(G, R, 1'b0, 30);
    push(Y, R, 1'b0, 10);
    push(R, R, 1'b0, 5);
    push(R, G, 1'b1, 10);
    push(R, Y, 1'b0, 10);
    push(R, R, 1'b0, 5);
    push(G, R, 1'b0, 38);
    wait_cycles(27);
    ped_btn = 1'b1;
    wait_cycles(1);
    ped_btn = 1'b0;
    wait_cycles(82);

    // Press in the exact SIDE_G entry cycle is consumed by that service.
    do_reset();
    side_car = 1'b1;
    push(R, R, 1'b0, 1);
    push(G, R, 1'b0, 15);
    push(Y, R, 1'b0, 10);
    push(R, R, 1'b0, 5);
    push(R, G, 1'b1, 10);
    push(R, Y, 1'b0, 10);
    push(R, R, 1'b0, 5);
    push(G, R, 1'b0, 43);
    wait_cycles(30);
    ped_btn  = 1'b1;
    side_car = 1'b0;
    wait_cycles(1);
    ped_btn = 1'b0;
    wait_cycles(69);

    // Side car, timer holds done high during start.
    run_side_loop();

    // Reset mid-SIDE_Y with a pedestrian request pending; request is lost.
    do_reset();
    side_car = 1'b1;
    push(R, R, 1'b0, 1);
    push(G, R, 1'b0, 15);
    push(Y, R, 1'b0, 10);
    push(R, R, 1'b0, 5);
    push(R, G, 1'b0, 10);
    push(R, Y, 1'b0, 4);
    wait_cycles(42);
    ped_btn  = 1'b1;
    side_car = 1'b0;
    wait_cycles(1);
    ped_btn = 1'b0;
    wait_cycles(1);
    do_reset();
    push(R, R, 1'b0, 1);
    push(G, R, 1'b0, 38);
    wait_cycles(40);

    // Close the last segment and stop monitoring.
    flush_cnt++;
    mon_en = 1'b0;
    wait_cycles(2);
    check("exp_queue_empty", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
